mult_sequencer: RTL and testbench

Multi-cycle sequencer for the HI/LO multiply resource in the single-cycle MIPS core. The main controller raises `ld` when it decodes the mult opcode. This block takes that as `start` and runs a signed shift-add multiply over WIDTH+2 cycles. While it runs, it stalls the PC and register write-back, then commits the 2*WIDTH product to the HI/LO registers and serves mfhi/mflo reads.

---
 rtl/mult_sequencer_if.sv | 15 +
 rtl/mult_sequencer.sv | 72 +++++++
 tb/tb_mult_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: request/operand and stall/result signals between the core and the multiply sequencer.
interface mult_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mf_sel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;
  modport master (output start, a, b, mf_sel, input stall, busy, done, hi, lo, rd_data);
  modport slave  (input start, a, b, mf_sel, output stall, busy, done, hi, lo, rd_data);
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer: signed shift-add multiply over WIDTH+2 cycles, committing the product to HI/LO.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  mult_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t             state_q;
  logic [2*WIDTH-1:0] ma_q, acc_q;
  logic [WIDTH-1:0]   mb_q, hi_q, lo_q, a_mag, b_mag;
  logic [CW-1:0]      cnt_q;
  logic               neg_q, busy_q, done_q;
  // Magnitudes as unsigned: the most negative value negates to itself, which is 2^(WIDTH-1) unsigned.
  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            ma_q    <= {{WIDTH{1'b0}}, a_mag};
            mb_q    <= b_mag;
            neg_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // ma_q is pre-shifted each cycle, so it always equals |a| << count.
          acc_q   <= mb_q[0] ? acc_q + ma_q : acc_q;
          ma_q    <= ma_q << 1;
          mb_q    <= mb_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
        end
        FIX: begin
          {hi_q, lo_q} <= neg_q ? -acc_q : acc_q;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.stall   = (state_q == IDLE) ? bus.start : busy_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.mf_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed checks of timing, signed products, back-to-back issue and mid-run reset.
module tb_mult_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  mult_sequencer_if #(.WIDTH(32)) bus ();
  mult_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Entered at a negedge with the sequencer idle; cycle 0 is the cycle start is first seen.
  task automatic do_mult(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
    int cyc = 0;
    int st  = 0;
    bus.a = x; bus.b = y; bus.start = 1'b1;
    #1;
    while (!bus.done && cyc < 100) begin
      if (bus.stall) st++;
      if (cyc == 5) chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'd34);
    chk({tag, "_stall_cycles"}, 64'(st), 64'd34);
    chk({tag, "_stall_in_done"}, 64'(bus.stall), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask
  initial begin
    int np, first, second, cyc_done;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.mf_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    do_mult(32'd3, 32'd5, 32'h0, 32'hF, "m3x5");
    bus.mf_sel = 1'b0; #1;
    chk("mflo", 64'(bus.rd_data), 64'hF);
    bus.mf_sel = 1'b1; #1;
    chk("mfhi", 64'(bus.rd_data), 64'h0);
    chk("mf_stall", 64'(bus.stall), 64'd0);
    bus.mf_sel = 1'b0;
    @(negedge clk);
    do_mult(32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mneg2x3");
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, "mneg1xneg1");
    do_mult(32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "mminxmin");
    do_mult(32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, "mminx1");
    // Back-to-back: start stays high through DONE, next operands swapped in during DONE.
    bus.a = 32'd2; bus.b = 32'd9; bus.start = 1'b1;
    np = 0; first = -1; second = -1;
    for (int c = 0; c < 110; c++) begin
      if (bus.done) begin
        np++;
        if (np == 1) begin
          first = c;
          chk("b2b_first_lo", 64'(bus.lo), 64'd18);
          bus.a = 32'd7; bus.b = 32'd6;
        end else begin
          second = c;
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b_pulses", 64'(np), 64'd2);
    chk("b2b_first_cycle", 64'(first), 64'd34);
    chk("b2b_spacing", 64'(second - first), 64'd35);
    chk("b2b_lo", 64'(bus.lo), 64'd42);
    chk("b2b_hi", 64'(bus.hi), 64'd0);
    // Reset in cycle 10 of a run, with start also high on that edge.
    bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_stall_start", 64'(bus.stall), 64'd1);
    chk("mid_rst_hi", 64'(bus.hi), 64'd0);
    chk("mid_rst_lo", 64'(bus.lo), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    bus.start = 1'b0; #1;
    chk("mid_rst_stall_idle", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) cyc_done++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", 64'(cyc_done), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
